vec_cmd_arbiter: RTL and testbench

- Shares one vector unit (op/addrA/addrB/addrD/scalar/w_data command port, done pulse, r_data/v/yumi read-return port) between reqs_p requesters, e.g. host and DMA.
- Round-robin grant; single-issue: one command outstanding at a time.
- Latches the granted command, drives it to the unit and waits for completion.
- For reads, buffers the returned vector until the owning requester accepts it.

---
 rtl/vec_cmd_arbiter_pkg.sv | 23 ++
 rtl/vec_cmd_arbiter_rr_arb.sv | 32 +++
 rtl/vec_cmd_arbiter.sv | 173 +++++++++++++++++
 tb/tb_vec_cmd_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_cmd_arbiter_pkg.sv
// Shared definitions for the vector-unit command arbiter: opcodes and FSM states.
package vec_pkg;

    localparam logic [3:0] OP_READ  = 4'b1000;
    localparam logic [3:0] OP_WRITE = 4'b1001;
    localparam logic [3:0] OP_MMUL  = 4'b1111;

    // ALU opcodes: upper two bits select vector (00) or scalar (01) operand form
    localparam logic [1:0] ALU_VEC_PFX = 2'b00;
    localparam logic [1:0] ALU_SCL_PFX = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        BUSY,
        RESP
    } state_e;

    function automatic logic op_is_read(input logic [3:0] op);
        return op == OP_READ;
    endfunction

endpackage

// File: rtl/vec_cmd_arbiter_rr_arb.sv
// Combinational round-robin arbiter: grants the first request at or after ptr_i, wrapping.
module vec_rr_arb #(
    parameter  int unsigned reqs_p = 2,
    localparam int unsigned pw_lp  = (reqs_p > 1) ? $clog2(reqs_p) : 1
) (
    input  logic [reqs_p-1:0] req_i,
    input  logic [pw_lp-1:0]  ptr_i,
    output logic [reqs_p-1:0] grant_o,
    output logic [pw_lp-1:0]  grant_idx_o,
    output logic              v_o
);

    logic [pw_lp-1:0] idx;
    logic             found;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = '0;
        for (int unsigned i = 0; i < reqs_p; i++) begin
            idx = pw_lp'((32'(ptr_i) + i) % reqs_p);
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
            end
        end
        v_o = found;
    end

endmodule

// File: rtl/vec_cmd_arbiter.sv
// Single-issue round-robin sharing of one vector unit between reqs_p requesters,
// with a one-entry return buffer for read data.
module vec_cmd_arbiter
    import vec_pkg::*;
#(
    parameter  int unsigned els_p  = 12,
    parameter  int unsigned vlen_p = 4,
    parameter  int unsigned vdw_p  = 8,
    parameter  int unsigned reqs_p = 2,
    localparam int unsigned aw_lp  = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int unsigned dw_lp  = vlen_p * vdw_p,
    localparam int unsigned pw_lp  = (reqs_p > 1) ? $clog2(reqs_p) : 1
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [reqs_p-1:0]         req_v_i,
    output logic [reqs_p-1:0]         req_ready_o,
    input  logic [reqs_p*4-1:0]       req_op_i,
    input  logic [reqs_p*aw_lp-1:0]   req_addrA_i,
    input  logic [reqs_p*aw_lp-1:0]   req_addrB_i,
    input  logic [reqs_p*aw_lp-1:0]   req_addrD_i,
    input  logic [reqs_p*vdw_p-1:0]   req_scalar_i,
    input  logic [reqs_p*dw_lp-1:0]   req_w_data_i,
    output logic [reqs_p-1:0]         req_done_o,
    output logic [reqs_p-1:0]         resp_v_o,
    output logic [dw_lp-1:0]          resp_data_o,
    input  logic [reqs_p-1:0]         resp_yumi_i,
    output logic [3:0]                vu_op_o,
    output logic [aw_lp-1:0]          vu_addrA_o,
    output logic [aw_lp-1:0]          vu_addrB_o,
    output logic [aw_lp-1:0]          vu_addrD_o,
    output logic [vdw_p-1:0]          vu_scalar_o,
    output logic [dw_lp-1:0]          vu_w_data_o,
    output logic                      vu_v_o,
    input  logic                      vu_ready_i,
    input  logic                      vu_done_i,
    input  logic [dw_lp-1:0]          vu_r_data_i,
    input  logic                      vu_v_i,
    output logic                      vu_yumi_o
);

    typedef struct packed {
        logic [3:0]       op;
        logic [aw_lp-1:0] addr_a;
        logic [aw_lp-1:0] addr_b;
        logic [aw_lp-1:0] addr_d;
        logic [vdw_p-1:0] scalar;
        logic [dw_lp-1:0] w_data;
    } cmd_t;

    state_e           state_q, state_d;
    cmd_t             cmd_q, cmd_d;
    logic [pw_lp-1:0] owner_q, owner_d;
    logic [pw_lp-1:0] ptr_q, ptr_d;
    logic [dw_lp-1:0] rdata_q, rdata_d;
    logic             cap_q, cap_d;
    logic             done_q, done_d;

    logic [reqs_p-1:0] arb_grant;
    logic [pw_lp-1:0]  arb_idx;
    logic              arb_v;
    logic              is_read;

    vec_rr_arb #(.reqs_p(reqs_p)) u_arb (
        .req_i       (req_v_i),
        .ptr_i       (ptr_q),
        .grant_o     (arb_grant),
        .grant_idx_o (arb_idx),
        .v_o         (arb_v)
    );

    assign is_read = op_is_read(cmd_q.op);

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        rdata_d     = rdata_q;
        cap_d       = cap_q;
        done_d      = done_q;
        req_ready_o = '0;
        req_done_o  = '0;
        resp_v_o    = '0;
        vu_yumi_o   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (arb_v) begin
                    // the accept pulse is combinational, so hold it off while reset is asserted
                    req_ready_o = reset_n_i ? arb_grant : '0;
                    owner_d     = arb_idx;
                    ptr_d       = (arb_idx == pw_lp'(reqs_p - 1)) ? '0 : arb_idx + 1'b1;
                    state_d     = ISSUE;
                    for (int unsigned i = 0; i < reqs_p; i++) begin
                        if (arb_grant[i]) begin
                            cmd_d.op     = req_op_i[i*4 +: 4];
                            cmd_d.addr_a = req_addrA_i[i*aw_lp +: aw_lp];
                            cmd_d.addr_b = req_addrB_i[i*aw_lp +: aw_lp];
                            cmd_d.addr_d = req_addrD_i[i*aw_lp +: aw_lp];
                            cmd_d.scalar = req_scalar_i[i*vdw_p +: vdw_p];
                            cmd_d.w_data = req_w_data_i[i*dw_lp +: dw_lp];
                        end
                    end
                end
            end
            ISSUE: begin
                if (vu_ready_i) begin
                    cap_d   = 1'b0;
                    done_d  = 1'b0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                vu_yumi_o = is_read && !cap_q && vu_v_i;
                if (vu_yumi_o) begin
                    rdata_d = vu_r_data_i;
                    cap_d   = 1'b1;
                end
                if (vu_done_i) begin
                    done_d = 1'b1;
                end
                // data and done may land in either order; finish once both have been seen
                if (!is_read) begin
                    if (vu_done_i) begin
                        req_done_o[owner_q] = 1'b1;
                        state_d             = IDLE;
                    end
                end else if ((done_q || vu_done_i) && (cap_q || vu_yumi_o)) begin
                    req_done_o[owner_q] = 1'b1;
                    state_d             = RESP;
                end
            end
            RESP: begin
                resp_v_o[owner_q] = 1'b1;
                if (resp_yumi_i[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            rdata_q <= '0;
            cap_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            rdata_q <= rdata_d;
            cap_q   <= cap_d;
            done_q  <= done_d;
        end
    end

    assign vu_v_o      = (state_q == ISSUE);
    assign vu_op_o     = cmd_q.op;
    assign vu_addrA_o  = cmd_q.addr_a;
    assign vu_addrB_o  = cmd_q.addr_b;
    assign vu_addrD_o  = cmd_q.addr_d;
    assign vu_scalar_o = cmd_q.scalar;
    assign vu_w_data_o = cmd_q.w_data;
    assign resp_data_o = rdata_q;

endmodule

// File: tb/tb_vec_cmd_arbiter.sv
// Self-checking bench for vec_cmd_arbiter: directed scenarios plus a randomized run
// against a phase-level reference model of the arbitration and completion rules.
module tb_vec_cmd_arbiter;

    localparam int unsigned ELS  = 12;
    localparam int unsigned VLEN = 4;
    localparam int unsigned VDW  = 8;
    localparam int unsigned REQS = 2;
    localparam int unsigned AW   = 4;
    localparam int unsigned DW   = 32;

    typedef enum int {P_IDLE, P_ISSUE, P_BUSY, P_RESP} ph_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [REQS-1:0]      req_v_i, req_ready_o, req_done_o, resp_v_o, resp_yumi_i;
    logic [REQS*4-1:0]    req_op_i;
    logic [REQS*AW-1:0]   req_addrA_i, req_addrB_i, req_addrD_i;
    logic [REQS*VDW-1:0]  req_scalar_i;
    logic [REQS*DW-1:0]   req_w_data_i;
    logic [DW-1:0]        resp_data_o, vu_w_data_o, vu_r_data_i;
    logic [3:0]           vu_op_o;
    logic [AW-1:0]        vu_addrA_o, vu_addrB_o, vu_addrD_o;
    logic [VDW-1:0]       vu_scalar_o;
    logic                 vu_v_o, vu_ready_i, vu_done_i, vu_v_i, vu_yumi_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vec_cmd_arbiter #(.els_p(ELS), .vlen_p(VLEN), .vdw_p(VDW), .reqs_p(REQS)) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_addrA_i(req_addrA_i), .req_addrB_i(req_addrB_i), .req_addrD_i(req_addrD_i),
        .req_scalar_i(req_scalar_i), .req_w_data_i(req_w_data_i),
        .req_done_o(req_done_o), .resp_v_o(resp_v_o), .resp_data_o(resp_data_o),
        .resp_yumi_i(resp_yumi_i),
        .vu_op_o(vu_op_o), .vu_addrA_o(vu_addrA_o), .vu_addrB_o(vu_addrB_o),
        .vu_addrD_o(vu_addrD_o), .vu_scalar_o(vu_scalar_o), .vu_w_data_o(vu_w_data_o),
        .vu_v_o(vu_v_o), .vu_ready_i(vu_ready_i), .vu_done_i(vu_done_i),
        .vu_r_data_i(vu_r_data_i), .vu_v_i(vu_v_i), .vu_yumi_o(vu_yumi_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_v_i = '0; req_op_i = '0; req_addrA_i = '0; req_addrB_i = '0; req_addrD_i = '0;
        req_scalar_i = '0; req_w_data_i = '0; resp_yumi_i = '0;
        vu_ready_i = 1'b0; vu_done_i = 1'b0; vu_r_data_i = '0; vu_v_i = 1'b0;
    endtask

    task automatic set_req(input int r, input logic [3:0] op, input logic [AW-1:0] a,
                           input logic [AW-1:0] b, input logic [AW-1:0] d,
                           input logic [VDW-1:0] s, input logic [DW-1:0] w);
        req_op_i[r*4 +: 4]       = op;
        req_addrA_i[r*AW +: AW]  = a;
        req_addrB_i[r*AW +: AW]  = b;
        req_addrD_i[r*AW +: AW]  = d;
        req_scalar_i[r*VDW +: VDW] = s;
        req_w_data_i[r*DW +: DW] = w;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Requester chosen by the round-robin rule: first valid at or after p, wrapping.
    function automatic int rr_pick(input logic [REQS-1:0] m, input int p);
        for (int k = 0; k < REQS; k++) begin
            if (m[(p + k) % REQS]) return (p + k) % REQS;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        req_v_i = '1; vu_done_i = 1'b1; vu_v_i = 1'b1; resp_yumi_i = '1; vu_ready_i = 1'b1;
        step(); step();
        #1;
        n_cmp++; if (req_ready_o !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b want 00", req_ready_o); end
        n_cmp++; if (req_done_o !== 2'b00) begin n_err++; $display("FAIL reset_done: got %b want 00", req_done_o); end
        n_cmp++; if (resp_v_o !== 2'b00) begin n_err++; $display("FAIL reset_resp_v: got %b want 00", resp_v_o); end
        n_cmp++; if (resp_data_o !== 32'h0) begin n_err++; $display("FAIL reset_resp_data: got %h want 0", resp_data_o); end
        n_cmp++; if (vu_v_o !== 1'b0 || vu_yumi_o !== 1'b0) begin n_err++; $display("FAIL reset_vu: got v=%b yumi=%b want 0 0", vu_v_o, vu_yumi_o); end
        n_cmp++; if ({vu_op_o, vu_addrA_o, vu_addrB_o, vu_addrD_o, vu_scalar_o, vu_w_data_o} !== '0) begin
            n_err++; $display("FAIL reset_cmd: got op=%h w=%h want 0", vu_op_o, vu_w_data_o); end
        clear_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_single_write();
        do_reset();
        set_req(0, 4'b1001, 4'h0, 4'h0, 4'h0, 8'h00, 32'h01010101);
        req_v_i = 2'b01;
        #1;
        n_cmp++; if (req_ready_o !== 2'b01) begin n_err++; $display("FAIL wr_ready: got %b want 01", req_ready_o); end
        step();
        req_v_i = '0; vu_ready_i = 1'b1;
        #1;
        n_cmp++; if (vu_v_o !== 1'b1) begin n_err++; $display("FAIL wr_vu_v: got %b want 1", vu_v_o); end
        n_cmp++; if (vu_op_o !== 4'b1001 || vu_addrD_o !== 4'h0 || vu_w_data_o !== 32'h01010101) begin
            n_err++; $display("FAIL wr_fields: got op=%b d=%h w=%h want 1001 0 01010101", vu_op_o, vu_addrD_o, vu_w_data_o); end
        step();
        vu_ready_i = 1'b0; vu_done_i = 1'b1;
        #1;
        n_cmp++; if (vu_v_o !== 1'b0) begin n_err++; $display("FAIL wr_vu_v_drop: got %b want 0", vu_v_o); end
        n_cmp++; if (req_done_o !== 2'b01) begin n_err++; $display("FAIL wr_done: got %b want 01", req_done_o); end
        step();
        vu_done_i = 1'b0;
        #1;
        n_cmp++; if (req_done_o !== 2'b00) begin n_err++; $display("FAIL wr_done_pulse: got %b want 00", req_done_o); end
    endtask

    task automatic test_rr_order();
        int pend [REQS];
        int p, g, grants, dones, cyc;
        logic acc;
        logic [REQS-1:0] drop, exp_oh;
        do_reset();
        for (int r = 0; r < REQS; r++) begin
            set_req(r, 4'b1001, 4'(r), 4'(r), 4'(r + 2), 8'(r), 32'hA0 + 32'(r));
            pend[r] = 4;
        end
        req_v_i = '1; p = 0; grants = 0; dones = 0; acc = 1'b0; cyc = 0; drop = '0;
        while (dones < 8 && cyc < 200) begin
            vu_ready_i = 1'b1;
            vu_done_i  = acc;
            #1;
            if (req_ready_o !== 2'b00) begin
                g = rr_pick(req_v_i, p);
                exp_oh = '0;
                if (g >= 0) exp_oh[g] = 1'b1;
                n_cmp++; if (req_ready_o !== exp_oh) begin n_err++; $display("FAIL rr_grant%0d: got %b want %b", grants, req_ready_o, exp_oh); end
                if (g >= 0) begin
                    pend[g]--;
                    p = (g + 1) % REQS;
                    if (pend[g] == 0) drop[g] = 1'b1;
                end
                grants++;
            end
            if (req_done_o !== 2'b00) dones++;
            acc = vu_v_o && vu_ready_i;
            step();
            req_v_i = req_v_i & ~drop;
            drop = '0;
            cyc++;
        end
        n_cmp++; if (grants !== 8) begin n_err++; $display("FAIL rr_grant_count: got %0d want 8", grants); end
        n_cmp++; if (dones !== 8) begin n_err++; $display("FAIL rr_done_count: got %0d want 8", dones); end
    endtask

    task automatic test_read_hold();
        do_reset();
        set_req(1, 4'b1000, 4'h8, 4'h0, 4'h0, 8'h00, 32'h0);
        set_req(0, 4'b1001, 4'h1, 4'h2, 4'h3, 8'h44, 32'hCAFE0001);
        req_v_i = 2'b10;
        #1;
        n_cmp++; if (req_ready_o !== 2'b10) begin n_err++; $display("FAIL rd_ready: got %b want 10", req_ready_o); end
        step();
        req_v_i = 2'b01; vu_ready_i = 1'b1;
        #1;
        n_cmp++; if (vu_v_o !== 1'b1 || vu_op_o !== 4'b1000 || vu_addrA_o !== 4'h8) begin
            n_err++; $display("FAIL rd_issue: got v=%b op=%b a=%h want 1 1000 8", vu_v_o, vu_op_o, vu_addrA_o); end
        n_cmp++; if (req_ready_o !== 2'b00) begin n_err++; $display("FAIL rd_no_grant_issue: got %b want 00", req_ready_o); end
        step();
        vu_ready_i = 1'b0; vu_v_i = 1'b1; vu_done_i = 1'b1; vu_r_data_i = 32'h08080706;
        #1;
        n_cmp++; if (vu_yumi_o !== 1'b1) begin n_err++; $display("FAIL rd_yumi: got %b want 1", vu_yumi_o); end
        n_cmp++; if (req_done_o !== 2'b10) begin n_err++; $display("FAIL rd_done: got %b want 10", req_done_o); end
        step();
        vu_v_i = 1'b0; vu_done_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            vu_r_data_i = $urandom;
            resp_yumi_i = (k == 1) ? 2'b01 : 2'b00;
            #1;
            n_cmp++; if (resp_v_o !== 2'b10 || resp_data_o !== 32'h08080706) begin
                n_err++; $display("FAIL rd_hold%0d: got v=%b d=%h want 10 08080706", k, resp_v_o, resp_data_o); end
            n_cmp++; if (req_ready_o !== 2'b00) begin n_err++; $display("FAIL rd_no_grant_resp%0d: got %b want 00", k, req_ready_o); end
            step();
        end
        resp_yumi_i = 2'b10;
        #1;
        n_cmp++; if (resp_v_o !== 2'b10 || req_ready_o !== 2'b00) begin
            n_err++; $display("FAIL rd_yumi_cycle: got v=%b ready=%b want 10 00", resp_v_o, req_ready_o); end
        step();
        resp_yumi_i = 2'b00;
        #1;
        n_cmp++; if (resp_v_o !== 2'b00) begin n_err++; $display("FAIL rd_resp_clear: got %b want 00", resp_v_o); end
        n_cmp++; if (req_ready_o !== 2'b01) begin n_err++; $display("FAIL rd_next_grant: got %b want 01", req_ready_o); end
    endtask

    task automatic test_mmul_stall();
        do_reset();
        set_req(0, 4'b1111, 4'h0, 4'h4, 4'h8, 8'h5A, 32'h13572468);
        req_v_i = 2'b01;
        #1;
        n_cmp++; if (req_ready_o !== 2'b01) begin n_err++; $display("FAIL mm_ready: got %b want 01", req_ready_o); end
        step();
        req_v_i = '0;
        for (int k = 0; k < 3; k++) begin
            vu_ready_i = (k == 2);
            #1;
            n_cmp++; if ({vu_v_o, vu_op_o, vu_addrA_o, vu_addrB_o, vu_addrD_o, vu_scalar_o, vu_w_data_o}
                        !== {1'b1, 4'b1111, 4'h0, 4'h4, 4'h8, 8'h5A, 32'h13572468}) begin
                n_err++; $display("FAIL mm_stable%0d: got v=%b op=%b a=%h b=%h d=%h s=%h w=%h", k,
                                  vu_v_o, vu_op_o, vu_addrA_o, vu_addrB_o, vu_addrD_o, vu_scalar_o, vu_w_data_o); end
            step();
        end
        vu_ready_i = 1'b0;
        #1;
        n_cmp++; if (vu_v_o !== 1'b0 || req_done_o !== 2'b00) begin
            n_err++; $display("FAIL mm_busy_wait: got v=%b done=%b want 0 00", vu_v_o, req_done_o); end
        step();
        vu_done_i = 1'b1;
        #1;
        n_cmp++; if (req_done_o !== 2'b01) begin n_err++; $display("FAIL mm_done: got %b want 01", req_done_o); end
        step();
        vu_done_i = 1'b0;
        #1;
        n_cmp++; if (req_done_o !== 2'b00 || vu_v_o !== 1'b0) begin
            n_err++; $display("FAIL mm_after: got done=%b v=%b want 00 0", req_done_o, vu_v_o); end
    endtask

    task automatic test_read_early_data();
        do_reset();
        set_req(0, 4'b1000, 4'h3, 4'h0, 4'h0, 8'h00, 32'h0);
        req_v_i = 2'b01;
        step();
        req_v_i = '0; vu_ready_i = 1'b1;
        step();
        vu_ready_i = 1'b0; vu_v_i = 1'b1; vu_r_data_i = 32'hDEADBEEF;
        #1;
        n_cmp++; if (vu_yumi_o !== 1'b1 || req_done_o !== 2'b00) begin
            n_err++; $display("FAIL early_b0: got yumi=%b done=%b want 1 00", vu_yumi_o, req_done_o); end
        step();
        vu_r_data_i = 32'h11111111;
        #1;
        n_cmp++; if (vu_yumi_o !== 1'b0 || req_done_o !== 2'b00 || resp_v_o !== 2'b00) begin
            n_err++; $display("FAIL early_b1: got yumi=%b done=%b resp=%b want 0 00 00", vu_yumi_o, req_done_o, resp_v_o); end
        step();
        vu_v_i = 1'b0; vu_done_i = 1'b1;
        #1;
        n_cmp++; if (req_done_o !== 2'b01 || resp_v_o !== 2'b00 || vu_yumi_o !== 1'b0) begin
            n_err++; $display("FAIL early_done: got done=%b resp=%b yumi=%b want 01 00 0", req_done_o, resp_v_o, vu_yumi_o); end
        step();
        vu_done_i = 1'b0;
        #1;
        n_cmp++; if (resp_v_o !== 2'b01 || resp_data_o !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL early_resp: got v=%b d=%h want 01 deadbeef", resp_v_o, resp_data_o); end
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        set_req(0, 4'b1001, 4'h2, 4'h2, 4'h2, 8'h22, 32'h22222222);
        set_req(1, 4'b1001, 4'h3, 4'h3, 4'h3, 8'h33, 32'h33333333);
        req_v_i = 2'b01;
        step();
        req_v_i = '0; vu_ready_i = 1'b1;
        step();
        rst_n = 1'b0; req_v_i = 2'b11; vu_done_i = 1'b1; vu_v_i = 1'b1;
        #1;
        n_cmp++; if ({req_ready_o, req_done_o, resp_v_o, vu_v_o, vu_yumi_o} !== '0 || vu_op_o !== 4'h0) begin
            n_err++; $display("FAIL rst_mid: got ready=%b done=%b resp=%b v=%b yumi=%b op=%h want all 0",
                              req_ready_o, req_done_o, resp_v_o, vu_v_o, vu_yumi_o, vu_op_o); end
        step(); step();
        rst_n = 1'b1; vu_done_i = 1'b0; vu_v_i = 1'b0;
        #1;
        n_cmp++; if (req_ready_o !== 2'b01 || req_done_o !== 2'b00) begin
            n_err++; $display("FAIL rst_mid_regrant: got ready=%b done=%b want 01 00", req_ready_o, req_done_o); end
    endtask

    task automatic test_random(input int ncyc);
        ph_t ph;
        int own, ptr, g, cnt_d, cnt_n, ndone, nobs;
        logic [3:0] e_op, op;
        logic [AW-1:0] e_a, e_b, e_d;
        logic [VDW-1:0] e_s;
        logic [DW-1:0] e_w, cap_data;
        logic cap, dn, taken, dsent, e_vuv, e_yumi, is_rd;
        logic [REQS-1:0] e_ready, e_done, e_resp, drop;
        do_reset();
        ph = P_IDLE; ptr = 0; own = 0; ndone = 0; nobs = 0;
        cap = 1'b0; dn = 1'b0; taken = 1'b0; dsent = 1'b0; cnt_d = 0; cnt_n = 0;
        e_op = '0; e_a = '0; e_b = '0; e_d = '0; e_s = '0; e_w = '0; cap_data = '0;
        for (int c = 0; c < ncyc; c++) begin
            for (int r = 0; r < REQS; r++) begin
                if (!req_v_i[r] && ($urandom % 3 == 0)) begin
                    case ($urandom % 4)
                        0: op = 4'b1000;
                        1: op = 4'b1001;
                        2: op = 4'b1111;
                        default: op = 4'($urandom % 8);
                    endcase
                    set_req(r, op, 4'($urandom % ELS), 4'($urandom % ELS), 4'($urandom % ELS), 8'($urandom), $urandom);
                    req_v_i[r] = 1'b1;
                end
            end
            vu_ready_i  = 1'($urandom);
            vu_r_data_i = $urandom;
            vu_v_i      = (ph == P_BUSY) && cnt_d == 0 && !taken;
            vu_done_i   = (ph == P_BUSY) && cnt_n == 0 && !dsent;
            resp_yumi_i = REQS'($urandom);
            #1;
            e_ready = '0; e_done = '0; e_resp = '0; e_vuv = 1'b0; e_yumi = 1'b0; g = -1;
            is_rd = (e_op == 4'b1000);
            case (ph)
                P_IDLE:  if (req_v_i != '0) begin g = rr_pick(req_v_i, ptr); e_ready[g] = 1'b1; end
                P_ISSUE: e_vuv = 1'b1;
                P_BUSY: begin
                    e_yumi = is_rd && !cap && vu_v_i;
                    e_done[own] = is_rd ? ((dn || vu_done_i) && (cap || e_yumi)) : vu_done_i;
                end
                P_RESP:  e_resp[own] = 1'b1;
                default: ;
            endcase
            n_cmp++; if (req_ready_o !== e_ready) begin n_err++; $display("FAIL rnd_ready@%0d: got %b want %b", c, req_ready_o, e_ready); end
            n_cmp++; if (vu_v_o !== e_vuv) begin n_err++; $display("FAIL rnd_vu_v@%0d: got %b want %b", c, vu_v_o, e_vuv); end
            n_cmp++; if (vu_yumi_o !== e_yumi) begin n_err++; $display("FAIL rnd_yumi@%0d: got %b want %b", c, vu_yumi_o, e_yumi); end
            n_cmp++; if (req_done_o !== e_done) begin n_err++; $display("FAIL rnd_done@%0d: got %b want %b", c, req_done_o, e_done); end
            n_cmp++; if (resp_v_o !== e_resp) begin n_err++; $display("FAIL rnd_resp_v@%0d: got %b want %b", c, resp_v_o, e_resp); end
            if (e_vuv) begin
                n_cmp++; if ({vu_op_o, vu_addrA_o, vu_addrB_o, vu_addrD_o, vu_scalar_o, vu_w_data_o} !== {e_op, e_a, e_b, e_d, e_s, e_w}) begin
                    n_err++; $display("FAIL rnd_fields@%0d: got op=%h a=%h b=%h d=%h s=%h w=%h want %h %h %h %h %h %h", c,
                                      vu_op_o, vu_addrA_o, vu_addrB_o, vu_addrD_o, vu_scalar_o, vu_w_data_o, e_op, e_a, e_b, e_d, e_s, e_w); end
            end
            if (ph == P_RESP) begin
                n_cmp++; if (resp_data_o !== cap_data) begin n_err++; $display("FAIL rnd_resp_data@%0d: got %h want %h", c, resp_data_o, cap_data); end
            end
            if (req_done_o !== '0) nobs++;
            drop = '0;
            case (ph)
                P_IDLE: if (g >= 0) begin
                    own = g;
                    e_op = req_op_i[g*4 +: 4];
                    e_a = req_addrA_i[g*AW +: AW]; e_b = req_addrB_i[g*AW +: AW]; e_d = req_addrD_i[g*AW +: AW];
                    e_s = req_scalar_i[g*VDW +: VDW]; e_w = req_w_data_i[g*DW +: DW];
                    ptr = (g + 1) % REQS; drop[g] = 1'b1; ph = P_ISSUE;
                end
                P_ISSUE: if (vu_ready_i) begin
                    ph = P_BUSY; cap = 1'b0; dn = 1'b0; taken = 1'b0; dsent = 1'b0;
                    cnt_d = $urandom % 4; cnt_n = $urandom % 4;
                end
                P_BUSY: begin
                    if (e_yumi) begin cap = 1'b1; cap_data = vu_r_data_i; taken = 1'b1; end
                    if (vu_done_i) begin dn = 1'b1; dsent = 1'b1; end
                    if (cnt_d > 0) cnt_d--;
                    if (cnt_n > 0) cnt_n--;
                    if (e_done != '0) begin ndone++; ph = is_rd ? P_RESP : P_IDLE; end
                end
                P_RESP: if (resp_yumi_i[own]) ph = P_IDLE;
                default: ;
            endcase
            step();
            req_v_i = req_v_i & ~drop;
        end
        n_cmp++; if (nobs !== ndone) begin n_err++; $display("FAIL rnd_done_count: got %0d want %0d", nobs, ndone); end
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        test_reset();
        test_single_write();
        test_rr_order();
        test_read_hold();
        test_mmul_stall();
        test_read_early_data();
        test_reset_mid_busy();
        test_random(1500);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog");
    end

endmodule
